memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Memory-side responder for the cache interface: accepts instruction-fetch requests from the icache and load/store requests from the dcache, and arbitrates them onto a single-ported RAM. It sits between the caches block and the RAM model/controller. It generates the per-requester wait handshakes and returns load data. A registered grant FSM serializes accesses, applies round-robin priority when both caches request, and uses a watchdog to release a stalled RAM access.

## Interface

**Parameters**

- `WORD_W`, 32, data and address width.
- `TIMEOUT`, 64, maximum cycles a grant may stay un-ACCESSed before it is aborted.

**Ports**

- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in 1: icache read request.
- `iaddr` in WORD_W: icache word address.
- `iwait` out 1: high while the icache request is not complete.
- `iload` out WORD_W: instruction data, valid when `iREN && !iwait`.
- `dREN` in 1: dcache read request.
- `dWEN` in 1: dcache write request.
- `daddr` in WORD_W: dcache word address.
- `dstore` in WORD_W: dcache write data.
- `dwait` out 1: high while the dcache request is not complete.
- `dload` out WORD_W: load data, valid when `dREN && !dwait`.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out WORD_W: RAM address.
- `ramstore` out WORD_W: RAM write data.
- `ramload` in WORD_W: RAM read data.
- `ramstate` in 2: `ramstate_t` value, one of FREE, BUSY, ACCESS, ERROR.
- `memerr` out 1: sticky; set on RAM ERROR or watchdog timeout.

## Operation

**FSM states:** IDLE, IGRANT, DGRANT.

**Transitions out of IDLE**
- If only a dcache request (`dREN|dWEN`) is pending, go to DGRANT.
- If only `iREN` is pending, go to IGRANT.
- If both are pending, grant the side not granted last. The `last_d` flop resets to 0, so the first contested grant goes to D.

**Behaviour in a grant state**
- Drive `ramaddr` from the granted requester.
- In DGRANT: `ramWEN=dWEN`, `ramREN=dREN&!dWEN`, and `ramstore=dstore`. Simultaneous `dREN` and `dWEN` is treated as a write.
- In IGRANT: `ramREN=1`.
- On `ramstate==ACCESS`:
  - Deassert the granted requester's wait for that cycle.
  - Pass `ramload` to `iload`/`dload` combinationally.
  - Update `last_d`.
  - Return to IDLE.
- On `ramstate==ERROR`, or when the watchdog reaches `TIMEOUT`:
  - Set `memerr`.
  - Deassert the requester's wait for one cycle so it does not hang. Load data is undefined in this case.
  - Return to IDLE.
- If the granted request drops before ACCESS, return to IDLE the next cycle with no wait pulse.

**Wait outputs**
- A requester's wait is high whenever it requests and is not completing this cycle.
- A wait is low when its requester is idle.
- `iwait` and `dwait` are never both low while both sides request.

**Watchdog**
- Counts cycles in a grant state.
- Clears on entry to IDLE.
- Width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.

**Data outputs outside ACCESS:** `iload`/`dload` follow `ramload` (don't-care). Benches check them only on completion.

**Address handling:** addresses pass through unmodified. The word-alignment check belongs to the caches.

## Timing

- **Reset values:** FSM=IDLE, `last_d`=0, watchdog=0, `memerr`=0.
- **Outputs after reset:** `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0. With no requests, `iwait`=`dwait`=0.
- **Grant latency:** request sampled in IDLE produces the grant state on the next edge. RAM strobes are asserted from that cycle.
- **Completion:** in the same cycle `ramstate==ACCESS`. Minimum request-to-`!wait` latency is 2 cycles when the RAM returns ACCESS on the first grant cycle.
- **Bubble:** one mandatory IDLE cycle between consecutive accesses. RAM strobes are low in IDLE.
- **Reset mid-access:** asynchronous return to IDLE. Strobes drop immediately; no completion pulse is produced.
- **Simultaneous events:** a new request arriving in the completion cycle is evaluated in the following IDLE cycle.

## Structure

- `cpu_types_pkg` holds `word_t` and `ramstate_t`; this block adds `arb_state_t` (IDLE, IGRANT, DGRANT) to it.
- One natural sub-module, `mem_watchdog`, provides a parameterized saturating counter with clear, enable, and an `expired` output.
- The FSM, priority flop, and output muxing stay in `memory_arbiter`.

## Test plan

- **Reset:** hold `nRST`=0 with `iREN`=1 → `ramREN`=0 and `memerr`=0. Release with ramstate=ACCESS → `iwait` low exactly 2 cycles after release, `iload`=`ramload`.
- **Contention:** `iREN`=1 with `iaddr`=0x100, and `dREN`=1 with `daddr`=0x200, both held; ramstate=ACCESS on every grant → grants alternate D(0x200), I(0x100), D, I. There is one IDLE cycle between grants, and `dwait`/`iwait` are never simultaneously low.
- **Store:** `dWEN`=1, `daddr`=0x40, `dstore`=0xDEADBEEF; ramstate BUSY for 3 cycles then ACCESS → `ramWEN`=1 with addr/data stable for 4 cycles, then `dwait` low for 1 cycle.
- **Timeout:** `TIMEOUT`=8, `iREN`=1, ramstate stuck BUSY → after 8 grant cycles `iwait` pulses low, `memerr`=1 and stays 1.
- **Withdrawal:** `dREN` drops in the 2nd BUSY cycle → state is IDLE next cycle, no `dwait` pulse, and a pending `iREN` is granted after that.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states and the memory arbiter grant states.
package cpu_types_pkg;

   localparam int unsigned WORD_WIDTH = 32;

   typedef logic [WORD_WIDTH-1:0] word_t;

   // Status reported by the RAM model/controller each cycle
   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ramstate_t;

   // Memory arbiter grant states
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IGRANT = 2'b01,
      DGRANT = 2'b10
   } arb_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// Saturating cycle counter with synchronous clear; flags when LIMIT cycles have been counted.
module mem_watchdog #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up and hold at LIMIT
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates icache fetches and dcache loads/stores onto a single-ported RAM,
// with round-robin priority under contention and a watchdog on stalled grants.
module memory_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic              memerr
);

   arb_state_t state_q, state_d;
   logic       last_d_q, last_d_d;
   logic       memerr_q, memerr_d;
   logic       ireq, dreq;
   logic       idone, ddone;
   logic       expired;

   mem_watchdog #(
      .LIMIT(TIMEOUT)
   ) u_watchdog (
      .clk_i    (CLK),
      .rst_ni   (nRST),
      .clr_i    (state_q == IDLE),
      .en_i     (state_q != IDLE),
      .expired_o(expired)
   );

   assign ireq = iREN;
   assign dreq = dREN | dWEN;

   // Grant selection, RAM strobe/address muxing and completion detection
   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      memerr_d = memerr_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      idone    = 1'b0;
      ddone    = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Under contention the side not served last wins; last_d_q=0 favours D
            if (dreq && (!ireq || !last_d_q)) begin
               state_d = DGRANT;
            end else if (ireq) begin
               state_d = IGRANT;
            end
         end
         IGRANT: begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (!ireq) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               idone    = 1'b1;
               last_d_d = 1'b0;
               state_d  = IDLE;
            end else if ((ramstate == ERROR) || expired) begin
               idone    = 1'b1;
               memerr_d = 1'b1;
               state_d  = IDLE;
            end
         end
         DGRANT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (!dreq) begin
               state_d = IDLE;
            end else if (ramstate == ACCESS) begin
               ddone    = 1'b1;
               last_d_d = 1'b1;
               state_d  = IDLE;
            end else if ((ramstate == ERROR) || expired) begin
               ddone    = 1'b1;
               memerr_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, round-robin priority and sticky error registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         memerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         memerr_q <= memerr_d;
      end
   end

   assign iwait  = ireq & ~idone;
   assign dwait  = dreq & ~ddone;
   assign iload  = ramload;
   assign dload  = ramload;
   assign memerr = memerr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed, table-driven bench for memory_arbiter (TIMEOUT overridden to 8).
module tb_memory_arbiter;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;
   logic        memerr;

   int checks;
   int failures;

   memory_arbiter #(
      .WORD_W (32),
      .TIMEOUT(8)
   ) dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .iREN    (iREN),
      .iaddr   (iaddr),
      .iwait   (iwait),
      .iload   (iload),
      .dREN    (dREN),
      .dWEN    (dWEN),
      .daddr   (daddr),
      .dstore  (dstore),
      .dwait   (dwait),
      .dload   (dload),
      .ramREN  (ramREN),
      .ramWEN  (ramWEN),
      .ramaddr (ramaddr),
      .ramstore(ramstore),
      .ramload (ramload),
      .ramstate(ramstate),
      .memerr  (memerr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One record per clock cycle: inputs applied after the falling edge, outputs checked 1 ns later
   typedef struct {
      logic        iren;
      logic [31:0] ia;
      logic        dren;
      logic        dwen;
      logic [31:0] da;
      logic [31:0] ds;
      ramstate_t   rs;
      logic [31:0] rl;
      logic        e_iw;
      logic        e_dw;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic        e_err;
      logic        chk_i;
      logic        chk_d;
   } vec_t;

   vec_t vq[$];

   function automatic void add(logic iren, logic [31:0] ia, logic dren, logic dwen,
                               logic [31:0] da, logic [31:0] ds, ramstate_t rs, logic [31:0] rl,
                               logic e_iw, logic e_dw, logic e_ren, logic e_wen,
                               logic [31:0] e_addr, logic [31:0] e_store, logic e_err,
                               logic chk_i, logic chk_d);
      vec_t v;
      v.iren = iren;   v.ia = ia;       v.dren = dren;    v.dwen = dwen;
      v.da = da;       v.ds = ds;       v.rs = rs;        v.rl = rl;
      v.e_iw = e_iw;   v.e_dw = e_dw;   v.e_ren = e_ren;  v.e_wen = e_wen;
      v.e_addr = e_addr; v.e_store = e_store; v.e_err = e_err;
      v.chk_i = chk_i; v.chk_d = chk_d;
      vq.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Global time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      checks   = 0;
      failures = 0;

      // Release reset: I served with immediate ACCESS (2-cycle latency)
      add(1,'h100,0,0,0,0,ACCESS,'h1111, 1,0,0,0,0,0,0, 0,0);
      add(1,'h100,0,0,0,0,ACCESS,'h2222, 0,0,1,0,'h100,0,0, 1,0);
      add(0,0,0,0,0,0,FREE,0,            0,0,0,0,0,0,0, 0,0);
      // Contention: D, I, D, I with an IDLE bubble between grants
      for (int k = 0; k < 2; k++) begin
         add(1,'h100,1,0,'h200,0,ACCESS,'h33, 1,1,0,0,0,0,0, 0,0);
         add(1,'h100,1,0,'h200,0,ACCESS,'h44, 1,0,1,0,'h200,0,0, 0,1);
         add(1,'h100,1,0,'h200,0,ACCESS,'h55, 1,1,0,0,0,0,0, 0,0);
         add(1,'h100,1,0,'h200,0,ACCESS,'h66, 0,1,1,0,'h100,0,0, 1,0);
      end
      // Store: three BUSY cycles then ACCESS
      add(0,0,0,1,'h40,'hDEADBEEF,BUSY,0, 0,1,0,0,0,0,0, 0,0);
      for (int k = 0; k < 3; k++)
         add(0,0,0,1,'h40,'hDEADBEEF,BUSY,0, 0,1,0,1,'h40,'hDEADBEEF,0, 0,0);
      add(0,0,0,1,'h40,'hDEADBEEF,ACCESS,'h77, 0,0,0,1,'h40,'hDEADBEEF,0, 0,0);
      // Withdrawal: dREN drops in 2nd BUSY cycle, pending iREN granted after
      add(0,0,1,0,'h300,0,BUSY,0,          0,1,0,0,0,0,0, 0,0);
      add(1,'h100,1,0,'h300,0,BUSY,0,      1,1,1,0,'h300,0,0, 0,0);
      add(1,'h100,0,0,'h300,0,BUSY,0,      1,0,0,0,'h300,0,0, 0,0);
      add(1,'h100,0,0,'h300,0,ACCESS,'h88, 1,0,0,0,0,0,0, 0,0);
      add(1,'h100,0,0,'h300,0,ACCESS,'h99, 0,0,1,0,'h100,0,0, 1,0);
      add(0,0,0,0,0,0,FREE,0,              0,0,0,0,0,0,0, 0,0);
      // Timeout: 8 BUSY grant cycles, abort on the 9th, memerr sticks
      add(1,'h80,0,0,0,0,BUSY,0, 1,0,0,0,0,0,0, 0,0);
      for (int k = 0; k < 8; k++)
         add(1,'h80,0,0,0,0,BUSY,0, 1,0,1,0,'h80,0,0, 0,0);
      add(1,'h80,0,0,0,0,BUSY,'hAB, 0,0,1,0,'h80,0,0, 0,0);
      add(0,0,0,0,0,0,FREE,0,       0,0,0,0,0,0,1, 0,0);
      add(0,0,0,0,0,0,FREE,0,       0,0,0,0,0,0,1, 0,0);
      // RAM ERROR on a dcache read releases dwait for one cycle
      add(0,0,1,0,'h10,0,ERROR,0, 0,1,0,0,0,0,1, 0,0);
      add(0,0,1,0,'h10,0,ERROR,0, 0,0,1,0,'h10,0,1, 0,0);
      add(0,0,0,0,0,0,FREE,0,     0,0,0,0,0,0,1, 0,0);

      // Reset held with a pending fetch
      nRST = 1'b0;
      iREN = 1'b1;  iaddr = 32'h100;
      dREN = 1'b0;  dWEN = 1'b0;  daddr = '0;  dstore = '0;
      ramstate = ACCESS;  ramload = '0;
      repeat (2) @(negedge CLK);
      #1;
      check("reset_ramREN",  ramREN,  0);
      check("reset_ramWEN",  ramWEN,  0);
      check("reset_ramaddr", ramaddr, 0);
      check("reset_memerr",  memerr,  0);
      check("reset_iwait",   iwait,   1);
      @(negedge CLK);
      nRST = 1'b1;

      foreach (vq[i]) begin
         iREN = vq[i].iren;  iaddr = vq[i].ia;
         dREN = vq[i].dren;  dWEN = vq[i].dwen;
         daddr = vq[i].da;   dstore = vq[i].ds;
         ramstate = vq[i].rs; ramload = vq[i].rl;
         #1;
         check($sformatf("row%0d iwait", i),    iwait,    vq[i].e_iw);
         check($sformatf("row%0d dwait", i),    dwait,    vq[i].e_dw);
         check($sformatf("row%0d ramREN", i),   ramREN,   vq[i].e_ren);
         check($sformatf("row%0d ramWEN", i),   ramWEN,   vq[i].e_wen);
         check($sformatf("row%0d ramaddr", i),  ramaddr,  vq[i].e_addr);
         check($sformatf("row%0d ramstore", i), ramstore, vq[i].e_store);
         check($sformatf("row%0d memerr", i),   memerr,   vq[i].e_err);
         if (vq[i].chk_i) check($sformatf("row%0d iload", i), iload, vq[i].rl);
         if (vq[i].chk_d) check($sformatf("row%0d dload", i), dload, vq[i].rl);
         if (vq[i].iren && (vq[i].dren || vq[i].dwen))
            check($sformatf("row%0d both_waits_low", i), {31'd0, ~iwait & ~dwait}, 0);
         @(negedge CLK);
      end

      // Reset asserted mid-grant: strobes drop at once, no completion pulse, memerr cleared
      iREN = 1'b0;  dREN = 1'b1;  dWEN = 1'b0;  daddr = 32'h77;
      ramstate = BUSY;
      #1;
      check("midrst_idle_dwait", dwait, 1);
      @(negedge CLK);
      #1;
      check("midrst_grant_ramREN", ramREN, 1);
      #2;
      nRST = 1'b0;
      #1;
      check("midrst_ramREN",  ramREN,  0);
      check("midrst_ramaddr", ramaddr, 0);
      check("midrst_dwait",   dwait,   1);
      check("midrst_memerr",  memerr,  0);
      @(negedge CLK);
      nRST = 1'b1;
      dREN = 1'b0;
      #1;
      check("postrst_dwait",  dwait,  0);
      check("postrst_ramREN", ramREN, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
